// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: phase encodings that the
// execute and other stages compare against, plus small address helpers.
package core_sequencer_pkg;

    localparam int unsigned STATE_W = 3;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [STATE_W-1:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WRITE  = 3'd4,
        HALT   = 3'd5
    } seq_state_e;

    function automatic logic is_misaligned(input logic [31:0] target);
        return target[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXEC/MEM/WRITE, owns
// the pc and retired-instruction counter, and parks in HALT on request or fault.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [STATE_W-1:0]   state,
    output logic [31:0]          pc,
    output logic                 fetch_req,
    input  logic                 fetch_done,
    input  logic                 mem_read_enabled,
    input  logic                 mem_write_enabled,
    output logic                 mem_req,
    input  logic                 mem_done,
    input  logic                 reg_write_enabled,
    input  logic [4:0]           reg_write_dest,
    output logic                 rf_we,
    input  logic                 is_jump_enabled,
    input  logic [31:0]          jump_dest,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 misaligned,
    output logic [31:0]          instret
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic        misaligned_q, misaligned_d;
    logic        mem_req_q, mem_req_d;
    logic        rf_we_q, rf_we_d;

    logic        mem_access;
    logic        rf_write;
    logic        bad_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instret_q    <= 32'd0;
            misaligned_q <= 1'b0;
            mem_req_q    <= 1'b0;
            rf_we_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instret_q    <= instret_d;
            misaligned_q <= misaligned_d;
            mem_req_q    <= mem_req_d;
            rf_we_q      <= rf_we_d;
        end
    end

    // mem_req and rf_we are registered sub-state bits so every strobe is a
    // pure function of flops; the first MEM cycle only samples the flags.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instret_d    = instret_q;
        misaligned_d = misaligned_q;
        mem_req_d    = 1'b0;
        rf_we_d      = 1'b0;

        mem_access = mem_read_enabled | mem_write_enabled;
        rf_write   = reg_write_enabled && (reg_write_dest != 5'd0);
        bad_target = is_jump_enabled && is_misaligned(jump_dest);

        unique case (state_q)
            FETCH: begin
                if (fetch_done) state_d = DECODE;
            end
            DECODE: state_d = EXEC;
            EXEC:   state_d = MEM;
            MEM: begin
                if (!mem_req_q) begin
                    if (mem_access) begin
                        mem_req_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                        rf_we_d = rf_write;
                    end
                end else if (mem_done) begin
                    state_d = WRITE;
                    rf_we_d = rf_write;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            WRITE: begin
                if (bad_target) begin
                    state_d      = HALT;
                    misaligned_d = 1'b1;
                end else begin
                    pc_d      = is_jump_enabled ? jump_dest : pc_q + PC_STEP;
                    instret_d = instret_q + 32'd1;
                    state_d   = halt_req ? HALT : FETCH;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // Gating with rst keeps the request low while reset is held even though
    // the state register already reads FETCH.
    assign fetch_req  = (state_q == FETCH) && !rst;
    assign state      = state_q;
    assign pc         = pc_q;
    assign mem_req    = mem_req_q;
    assign rf_we      = rf_we_q;
    assign halted     = (state_q == HALT);
    assign misaligned = misaligned_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: ALU, load, branch/store, wrap, halt,
// misaligned jump and reset behaviour with hand-computed expectations.
module tb_core_sequencer;

    logic        clk;
    logic        rst;
    logic [2:0]  state;
    logic [31:0] pc;
    logic        fetch_req;
    logic        fetch_done;
    logic        mem_read_enabled;
    logic        mem_write_enabled;
    logic        mem_req;
    logic        mem_done;
    logic        reg_write_enabled;
    logic [4:0]  reg_write_dest;
    logic        rf_we;
    logic        is_jump_enabled;
    logic [31:0] jump_dest;
    logic        halt_req;
    logic        halted;
    logic        misaligned;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;
    int mreq_cnt, rfwe_cnt, rf_at;

    core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst               (rst),
        .state             (state),
        .pc                (pc),
        .fetch_req         (fetch_req),
        .fetch_done        (fetch_done),
        .mem_read_enabled  (mem_read_enabled),
        .mem_write_enabled (mem_write_enabled),
        .mem_req           (mem_req),
        .mem_done          (mem_done),
        .reg_write_enabled (reg_write_enabled),
        .reg_write_dest    (reg_write_dest),
        .rf_we             (rf_we),
        .is_jump_enabled   (is_jump_enabled),
        .jump_dest         (jump_dest),
        .halt_req          (halt_req),
        .halted            (halted),
        .misaligned        (misaligned),
        .instret           (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles starting at the current negedge (cycle 1 = FETCH).
    // fetch_done is offered only in cycle 1; mem_done only in cycle done_at.
    task automatic run(input int n, input int done_at,
                       output int mreq, output int rfwe, output int rfat);
        mreq = 0;
        rfwe = 0;
        rfat = 0;
        for (int c = 1; c <= n; c++) begin
            fetch_done = (c == 1);
            mem_done   = (c == done_at);
            #1;
            if (mem_req) mreq++;
            if (rf_we) begin
                rfwe++;
                rfat = c;
            end
            @(negedge clk);
        end
        fetch_done = 1'b0;
        mem_done   = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fetch_done = 1'b0;
        mem_read_enabled = 1'b0;
        mem_write_enabled = 1'b0;
        mem_done = 1'b0;
        reg_write_enabled = 1'b0;
        reg_write_dest = 5'd0;
        is_jump_enabled = 1'b0;
        jump_dest = 32'd0;
        halt_req = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_fetch_req", {31'd0, fetch_req}, 32'd1);

        // ALU op, rd=5, no memory access
        reg_write_enabled = 1'b1;
        reg_write_dest = 5'd5;
        run(5, 0, mreq_cnt, rfwe_cnt, rf_at);
        check("alu_rfwe_count", rfwe_cnt, 1);
        check("alu_rfwe_cycle", rf_at, 5);
        check("alu_mreq_count", mreq_cnt, 0);
        check("alu_state", {29'd0, state}, 32'd0);
        check("alu_pc", pc, 32'h4);
        check("alu_instret", instret, 32'd1);

        // Load with mem_done three cycles into the request
        reg_write_dest = 5'd7;
        mem_read_enabled = 1'b1;
        run(8, 7, mreq_cnt, rfwe_cnt, rf_at);
        check("ld_mreq_count", mreq_cnt, 3);
        check("ld_rfwe_cycle", rf_at, 8);
        check("ld_state", {29'd0, state}, 32'd0);
        check("ld_pc", pc, 32'h8);
        check("ld_instret", instret, 32'd2);

        // Taken branch to 0x100 that is also a store with rd=0
        mem_read_enabled = 1'b0;
        mem_write_enabled = 1'b1;
        reg_write_dest = 5'd0;
        is_jump_enabled = 1'b1;
        jump_dest = 32'h100;
        run(6, 5, mreq_cnt, rfwe_cnt, rf_at);
        check("br_rfwe_count", rfwe_cnt, 0);
        check("br_mreq_count", mreq_cnt, 1);
        check("br_fetch_req", {31'd0, fetch_req}, 32'd1);
        check("br_pc", pc, 32'h100);
        check("br_instret", instret, 32'd3);

        // Jump to the top of the address space
        mem_write_enabled = 1'b0;
        reg_write_enabled = 1'b0;
        jump_dest = 32'hFFFF_FFFC;
        run(5, 0, mreq_cnt, rfwe_cnt, rf_at);
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_instret", instret, 32'd4);

        // Sequential step wraps pc, halt_req held through WRITE
        is_jump_enabled = 1'b0;
        halt_req = 1'b1;
        run(5, 0, mreq_cnt, rfwe_cnt, rf_at);
        check("wrap_pc", pc, 32'h0);
        check("wrap_instret", instret, 32'd5);
        check("halt_state", {29'd0, state}, 32'd5);
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_fetch_req", {31'd0, fetch_req}, 32'd0);
        fetch_done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("halt_stuck_state", {29'd0, state}, 32'd5);
        check("halt_stuck_fetch_req", {31'd0, fetch_req}, 32'd0);
        check("halt_stuck_instret", instret, 32'd5);
        fetch_done = 1'b0;

        // Reset out of HALT
        rst = 1'b1;
        halt_req = 1'b0;
        #1;
        check("rst2_state", {29'd0, state}, 32'd0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check("rst2_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // One ALU op to move pc off zero, then a misaligned jump with rd=3
        reg_write_enabled = 1'b1;
        reg_write_dest = 5'd3;
        run(5, 0, mreq_cnt, rfwe_cnt, rf_at);
        check("alu2_pc", pc, 32'h4);
        is_jump_enabled = 1'b1;
        jump_dest = 32'h102;
        run(5, 0, mreq_cnt, rfwe_cnt, rf_at);
        check("mis_rfwe_cycle", rf_at, 5);
        check("mis_state", {29'd0, state}, 32'd5);
        check("mis_flag", {31'd0, misaligned}, 32'd1);
        check("mis_halted", {31'd0, halted}, 32'd1);
        check("mis_pc", pc, 32'h4);
        check("mis_instret", instret, 32'd1);
        check("mis_fetch_req", {31'd0, fetch_req}, 32'd0);

        rst = 1'b1;
        #1;
        check("rst3_misaligned", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        is_jump_enabled = 1'b0;

        // Reset while a load is waiting on mem_done
        run(5, 0, mreq_cnt, rfwe_cnt, rf_at);
        check("pre_mid_pc", pc, 32'h4);
        mem_read_enabled = 1'b1;
        run(5, 0, mreq_cnt, rfwe_cnt, rf_at);
        check("mid_mem_req", {31'd0, mem_req}, 32'd1);
        check("mid_state", {29'd0, state}, 32'd3);
        rst = 1'b1;
        #1;
        check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        check("midrst_state", {29'd0, state}, 32'd0);
        check("midrst_pc", pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_read_enabled = 1'b0;
        mem_done = 1'b1;
        #1;
        check("midrst_fetch_req", {31'd0, fetch_req}, 32'd1);
        @(negedge clk);
        #1;
        check("midrst_hold_fetch", {29'd0, state}, 32'd0);
        check("midrst_no_mem_req", {31'd0, mem_req}, 32'd0);
        mem_done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
